data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/mips_pkg.sv | 16 +
 rtl/data_cache_if.sv | 29 ++
 rtl/data_cache_array.sv | 45 ++++
 rtl/data_cache.sv | 151 +++++++++++++++
 tb/tb_data_cache.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS data cache: bus word layouts, controller states, default geometry.
package mips_pkg;

  typedef logic [31:0]     word_t;
  typedef logic [0:3][7:0] byte_word_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RD_MISS     = 2'd1,
    WR_THRU     = 2'd2,
    REFILL_DONE = 2'd3
  } dcache_state_t;

  localparam int unsigned LINES_DEFAULT = 32;

endpackage

// File: rtl/data_cache_if.sv
// Core-side and memory-side buses of the data cache; slave is the cache, master the core/memory.
interface data_cache_if;
  import mips_pkg::*;

  word_t      cpu_addr;
  logic       cpu_rd;
  logic       cpu_we;
  byte_word_t cpu_wdata;
  byte_word_t cpu_rdata;
  logic       cpu_stall;

  word_t      mem_addr;
  logic       mem_req;
  logic       mem_we;
  byte_word_t mem_wdata;
  byte_word_t mem_rdata;
  logic       mem_ack;

  modport slave (
    input  cpu_addr, cpu_rd, cpu_we, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_stall, mem_addr, mem_req, mem_we, mem_wdata
  );

  modport master (
    output cpu_addr, cpu_rd, cpu_we, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_stall, mem_addr, mem_req, mem_we, mem_wdata
  );

endinterface

// File: rtl/data_cache_array.sv
// Direct-mapped line storage: valid/tag/data, combinational read, synchronous write and valid clear.
module dcache_array
  import mips_pkg::*;
#(
  parameter  int unsigned LINES = LINES_DEFAULT,
  localparam int unsigned IB    = $clog2(LINES),
  localparam int unsigned TB    = 30 - IB
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic [IB-1:0] rd_idx_i,
  output logic          rd_valid_o,
  output logic [TB-1:0] rd_tag_o,
  output byte_word_t    rd_data_o,
  input  logic          wr_en_i,
  input  logic [IB-1:0] wr_idx_i,
  input  logic [TB-1:0] wr_tag_i,
  input  byte_word_t    wr_data_i
);

  logic [LINES-1:0] valid_q;
  logic [TB-1:0]    tag_q  [LINES];
  byte_word_t       data_q [LINES];

  // Only the valid bits are cleared; stale tag/data are harmless behind valid=0.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/data_cache.sv
// Write-through, no-write-allocate, direct-mapped data cache with blocking miss handling.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
//   state       | meaning
//   IDLE        | serve hits, launch miss refill or write-through
//   RD_MISS     | read request to memory outstanding
//   WR_THRU     | write request to memory outstanding
//   REFILL_DONE | line refilled, replay load next cycle
module data_cache
  import mips_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEFAULT
) (
  input  logic  clk,
  input  logic  rst_b,
  data_cache_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned TB = 30 - IB;

  dcache_state_t state_q, state_d;

  logic [IB-1:0] idx;
  logic [TB-1:0] tag;
  logic          line_valid;
  logic [TB-1:0] line_tag;
  byte_word_t    line_data;
  logic          hit;
  logic          is_store;
  logic          is_load;
  logic          arr_we;
  byte_word_t    arr_wdata;
  logic          unused_addr_bits;

  assign idx              = bus.cpu_addr[2 +: IB];
  assign tag              = bus.cpu_addr[31 -: TB];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];
  assign hit              = line_valid && (line_tag == tag);
  assign is_store         = bus.cpu_we;
  assign is_load          = bus.cpu_rd && !bus.cpu_we;

  dcache_array #(.LINES(LINES)) u_array (
    .clk        (clk),
    .clr_i      (rst_b),
    .rd_idx_i   (idx),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .wr_en_i    (arr_we && !rst_b),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag),
    .wr_data_i  (arr_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.cpu_stall = 1'b0;
    bus.cpu_rdata = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    arr_we        = 1'b0;
    arr_wdata     = bus.mem_rdata;
    unique case (state_q)
      IDLE: begin
        if (is_store) begin
          bus.cpu_stall = 1'b1;
          state_d       = WR_THRU;
        end else if (is_load) begin
          if (hit) begin
            bus.cpu_rdata = line_data;
          end else begin
            bus.cpu_stall = 1'b1;
            state_d       = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        bus.cpu_stall = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = {bus.cpu_addr[31:2], 2'b00};
        if (bus.mem_ack) begin
          arr_we  = 1'b1;
          state_d = REFILL_DONE;
        end
      end
      WR_THRU: begin
        bus.cpu_stall = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {bus.cpu_addr[31:2], 2'b00};
        bus.mem_wdata = bus.cpu_wdata;
        // Release the core in the ack cycle; a hit keeps the line coherent with memory.
        if (bus.mem_ack) begin
          bus.cpu_stall = 1'b0;
          arr_we        = hit;
          arr_wdata     = bus.cpu_wdata;
          state_d       = IDLE;
        end
      end
      REFILL_DONE: begin
        bus.cpu_stall = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  word_t hit_cnt_q;
  word_t miss_cnt_q;
  logic  replay_q;

  // The hit that replays a just-refilled load belongs to that miss, not to the hit count.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      replay_q   <= 1'b0;
    end else begin
      replay_q <= (state_q == REFILL_DONE);
      if (state_q == IDLE && is_load && hit && !replay_q && hit_cnt_q != '1) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (state_q == REFILL_DONE && miss_cnt_q != '1) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Randomized self-checking bench for data_cache against a line-occupancy and main-memory model.
module tb_data_cache;
  import mips_pkg::*;

  localparam int unsigned LINES = 32;
  localparam int unsigned IB    = $clog2(LINES);

  typedef struct {
    word_t      addr;
    bit         we;
    byte_word_t data;
  } tx_t;

  logic clk;
  logic rst_b;

  data_cache_if bus ();

  data_cache #(.LINES(LINES)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  byte_word_t mem_model [word_t];
  bit         ref_valid [LINES];
  word_t      ref_line  [LINES];
  tx_t        txq [$];
  int         ack_delay  = 2;
  bit         inject_ack = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic byte_word_t mem_read(input word_t wa);
    if (mem_model.exists(wa)) return mem_model[wa];
    return {wa[15:0] ^ 16'h5A3C, ~wa[15:0]};
  endfunction

  // Memory responder: acks in the ack_delay-th cycle that mem_req is seen high.
  initial begin
    int   age;
    tx_t  t;
    age           = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (rst_b || !bus.mem_req) begin
        age = 0;
      end else begin
        age++;
        if (age >= ack_delay) begin
          age         = 0;
          bus.mem_ack = 1'b1;
          if (!bus.mem_we) bus.mem_rdata = mem_read(bus.mem_addr);
          t.addr = bus.mem_addr;
          t.we   = bus.mem_we;
          t.data = bus.mem_wdata;
          txq.push_back(t);
        end
      end
      if (inject_ack) bus.mem_ack = 1'b1;
    end
  end

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_b      = 1'b1;
    bus.cpu_rd = 1'b0;
    bus.cpu_we = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    bus.cpu_rd = 1'b0;
    bus.cpu_we = 1'b0;
    #2;
    check("idle_stall", bus.cpu_stall, 1'b0);
    check("idle_rdata", bus.cpu_rdata, '0);
  endtask

  // One core access held until stall drops; the model predicts latency, data and bus traffic.
  task automatic access(input bit is_wr, input bit both, input word_t addr,
                        input byte_word_t wd, input int dly);
    word_t      wa;
    int         idx;
    bit         exp_hit;
    int         stalls;
    int         exp_stalls;
    int         exp_tx;
    byte_word_t got_rd;
    wa      = {addr[31:2], 2'b00};
    idx     = int'((addr >> 2) & (LINES - 1));
    exp_hit = ref_valid[idx] && (ref_line[idx] == wa);
    @(posedge clk);
    #1;
    ack_delay     = dly;
    txq.delete();
    bus.cpu_addr  = addr;
    bus.cpu_we    = is_wr;
    bus.cpu_rd    = !is_wr || both;
    bus.cpu_wdata = wd;
    #2;
    stalls = 0;
    while (bus.cpu_stall && stalls < 200) begin
      if (stalls == 0) check("rdata_when_stalled", bus.cpu_rdata, '0);
      @(posedge clk);
      #3;
      stalls++;
    end
    got_rd = bus.cpu_rdata;
    if (is_wr) begin
      exp_stalls = dly;
      exp_tx     = 1;
    end else begin
      exp_stalls = exp_hit ? 0 : dly + 2;
      exp_tx     = exp_hit ? 0 : 1;
      check("load_rdata", got_rd, mem_read(wa));
      check("load_done_mem_req", bus.mem_req, 1'b0);
    end
    check("stall_cycles", stalls, exp_stalls);
    check("tx_count", txq.size(), exp_tx);
    if (txq.size() > 0) begin
      check("tx_addr", txq[0].addr, wa);
      check("tx_we", txq[0].we, is_wr);
      if (is_wr) check("tx_wdata", txq[0].data, wd);
    end
    if (is_wr) begin
      mem_model[wa] = wd;
    end else if (!exp_hit) begin
      ref_valid[idx] = 1'b1;
      ref_line[idx]  = wa;
    end
  endtask

  initial begin
    word_t a;
    rst_b         = 1'b1;
    bus.cpu_addr  = '0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < LINES; i++) begin
      ref_valid[i] = 1'b0;
      ref_line[i]  = '0;
    end
    mem_model[32'h0000_0040] = 32'hDEAD_BEEF;

    @(posedge clk);
    #3;
    check("rst_cpu_stall", bus.cpu_stall, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, '0);
    check("rst_mem_wdata", bus.mem_wdata, '0);
    check("rst_cpu_rdata", bus.cpu_rdata, '0);
    @(posedge clk);
    #1;
    rst_b = 1'b0;

    access(1'b0, 1'b0, 32'h0000_0040, '0, 3);
    check("first_refill_data", mem_read(32'h0000_0040), 32'hDEAD_BEEF);
    access(1'b0, 1'b0, 32'h0000_0040, '0, 3);
    access(1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678, 2);
    access(1'b0, 1'b0, 32'h0000_0043, '0, 2);
    idle_cycle();

    reset_dut();
    access(1'b0, 1'b0, 32'h0000_0040, '0, 2);
    access(1'b0, 1'b0, 32'h0000_00C0, '0, 4);
    access(1'b0, 1'b0, 32'h0000_0040, '0, 2);

    access(1'b1, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 3);
    access(1'b0, 1'b0, 32'h0000_0200, '0, 2);
    access(1'b1, 1'b1, 32'h0000_0200, 32'h0BAD_1DEA, 2);
    access(1'b0, 1'b0, 32'h0000_0200, '0, 2);
    idle_cycle();

    reset_dut();
    @(posedge clk);
    #1;
    ack_delay    = 1000;
    bus.cpu_addr = 32'h0000_0040;
    bus.cpu_rd   = 1'b1;
    bus.cpu_we   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("midmiss_mem_req", bus.mem_req, 1'b1);
    @(posedge clk);
    #1;
    rst_b      = 1'b1;
    bus.cpu_rd = 1'b0;
    @(posedge clk);
    #1;
    rst_b      = 1'b0;
    inject_ack = 1'b1;
    #2;
    check("after_rst_mem_req", bus.mem_req, 1'b0);
    check("after_rst_stall", bus.cpu_stall, 1'b0);
    @(posedge clk);
    #1;
    inject_ack = 1'b0;
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    access(1'b0, 1'b0, 32'h0000_0040, '0, 2);

    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      a = (word_t'($urandom_range(0, 3)) << (2 + IB)) |
          (word_t'($urandom_range(0, 7)) << 2) | word_t'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      if (r < 55)      access(1'b0, 1'b0, a, $urandom, $urandom_range(2, 5));
      else if (r < 88) access(1'b1, 1'b0, a, $urandom, $urandom_range(2, 5));
      else if (r < 95) access(1'b1, 1'b1, a, $urandom, $urandom_range(2, 5));
      else             idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
